lhca_period_monitor: RTL and testbench

- Downstream consumer of the linear hybrid cellular automaton (LHCA) generator; connects directly to the generator's WIDTH-bit state output (the J3-style bus).
- Measures the cycle period of the observed state sequence.
- Flags lock-up in the all-zero state, and flags failure to recur within 2^WIDTH steps.
- Reports whether the period is maximal (2^WIDTH-1); used on-board and in simulation to qualify LHCA rule vectors.

---
 rtl/lhca_pkg.sv | 22 ++
 rtl/lhca_period_monitor_if.sv | 24 ++
 rtl/lhca_step_counter.sv | 23 ++
 rtl/lhca_period_monitor.sv | 115 +++++++++++
 tb/tb_lhca_period_monitor.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/lhca_pkg.sv
// Shared types and helpers for the LHCA period monitor.
package lhca_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CAPTURE,
    COUNT,
    PASS,
    FAIL
  } state_t;

  // Longest possible cycle of a nonzero WIDTH-bit LHCA.
  function automatic int unsigned max_period(input int unsigned width);
    return (32'd1 << width) - 32'd1;
  endfunction

  // Step count at which a sequence that has not recurred is declared stuck.
  function automatic int unsigned timeout_limit(input int unsigned width);
    return 32'd1 << width;
  endfunction

endpackage

// File: rtl/lhca_period_monitor_if.sv
// Bus between an LHCA generator/driver (master) and the period monitor (slave).
interface lhca_period_monitor_if #(
  parameter int WIDTH     = 2,
  parameter int CNT_WIDTH = WIDTH + 1
);
  logic [WIDTH-1:0]     I;
  logic                 VALID;
  logic                 START;
  logic [CNT_WIDTH-1:0] PERIOD;
  logic                 DONE;
  logic                 MAXIMAL;
  logic                 ZERO_LOCK;
  logic                 TIMEOUT;

  modport master (
    output I, VALID, START,
    input  PERIOD, DONE, MAXIMAL, ZERO_LOCK, TIMEOUT
  );

  modport slave (
    input  I, VALID, START,
    output PERIOD, DONE, MAXIMAL, ZERO_LOCK, TIMEOUT
  );
endinterface

// File: rtl/lhca_step_counter.sv
// Step counter with synchronous clear/enable and asynchronous reset.
module lhca_step_counter #(
  parameter int CNT_WIDTH = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 en,
  output logic [CNT_WIDTH-1:0] count
);

  // Clear wins over enable so a restart never sees a stale increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + CNT_WIDTH'(1);
    end
  end

endmodule

// File: rtl/lhca_period_monitor.sv
// Measures the recurrence period of an LHCA state stream and flags
// all-zero lock-up or failure to recur within 2^WIDTH counted steps.
module lhca_period_monitor
  import lhca_pkg::*;
#(
  parameter int WIDTH     = 2,
  parameter int CNT_WIDTH = WIDTH + 1
) (
  input logic                   CLK,
  input logic                   RESET,
  lhca_period_monitor_if.slave  bus
);

  localparam logic [CNT_WIDTH-1:0] MAX_P = CNT_WIDTH'(max_period(WIDTH));
  localparam logic [CNT_WIDTH-1:0] LIMIT = CNT_WIDTH'(timeout_limit(WIDTH));

  state_t               state;
  logic [WIDTH-1:0]     ref_state;
  logic [CNT_WIDTH-1:0] count;
  logic [CNT_WIDTH-1:0] next_count;
  logic                 hit_ref;
  logic                 hit_zero;
  logic                 hit_limit;
  logic                 cnt_clr;
  logic                 cnt_en;

  logic [CNT_WIDTH-1:0] period;
  logic                 done;
  logic                 maximal;
  logic                 zero_lock;
  logic                 timeout;

  // Sample comparisons and counter control; START always forces a clear
  // and suppresses counting so the sample in that cycle is discarded.
  always_comb begin
    next_count = count + CNT_WIDTH'(1);
    hit_ref    = (bus.I == ref_state);
    hit_zero   = (bus.I == '0);
    hit_limit  = (next_count == LIMIT);
    cnt_clr    = bus.START || ((state == CAPTURE) && bus.VALID && !hit_zero);
    cnt_en     = !bus.START && (state == COUNT) && bus.VALID &&
                 !hit_ref && !hit_zero && !hit_limit;
  end

  lhca_step_counter #(
    .CNT_WIDTH (CNT_WIDTH)
  ) u_counter (
    .clk   (CLK),
    .rst   (RESET),
    .clr   (cnt_clr),
    .en    (cnt_en),
    .count (count)
  );

  // Measurement FSM with registered result outputs.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state     <= IDLE;
      ref_state <= '0;
      period    <= '0;
      done      <= 1'b0;
      maximal   <= 1'b0;
      zero_lock <= 1'b0;
      timeout   <= 1'b0;
    end else if (bus.START) begin
      state     <= CAPTURE;
      period    <= '0;
      done      <= 1'b0;
      maximal   <= 1'b0;
      zero_lock <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      case (state)
        CAPTURE: begin
          if (bus.VALID) begin
            if (hit_zero) begin
              zero_lock <= 1'b1;
              state     <= FAIL;
            end else begin
              ref_state <= bus.I;
              state     <= COUNT;
            end
          end
        end
        COUNT: begin
          if (bus.VALID) begin
            if (hit_ref) begin
              period  <= next_count;
              done    <= 1'b1;
              maximal <= (next_count == MAX_P);
              state   <= PASS;
            end else if (hit_zero) begin
              zero_lock <= 1'b1;
              state     <= FAIL;
            end else if (hit_limit) begin
              // Entered a cycle that excludes the reference state.
              timeout <= 1'b1;
              state   <= FAIL;
            end
          end
        end
        default: begin
          // IDLE, PASS and FAIL hold until START or RESET.
        end
      endcase
    end
  end

  assign bus.PERIOD    = period;
  assign bus.DONE      = done;
  assign bus.MAXIMAL   = maximal;
  assign bus.ZERO_LOCK = zero_lock;
  assign bus.TIMEOUT   = timeout;

endmodule

// File: tb/tb_lhca_period_monitor.sv
// Directed bench for lhca_period_monitor (WIDTH=2) with an outcome scoreboard.
module tb_lhca_period_monitor;
  import lhca_pkg::*;

  logic CLK = 1'b0;
  logic RESET;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [2:0] period;
    logic       done;
    logic       maximal;
    logic       zero_lock;
    logic       timeout;
  } exp_t;

  exp_t sb[$];

  lhca_period_monitor_if #(.WIDTH(2)) bus ();

  lhca_period_monitor #(.WIDTH(2)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs at the falling edge, return just after the rising edge.
  task automatic step(input logic s, input logic v, input logic [1:0] i);
    @(negedge CLK);
    bus.START = s;
    bus.VALID = v;
    bus.I     = i;
    @(posedge CLK);
    #1;
  endtask

  task automatic push_exp(input logic [2:0] p, input logic d, input logic m,
                          input logic z, input logic t);
    exp_t e;
    e.period = p; e.done = d; e.maximal = m; e.zero_lock = z; e.timeout = t;
    sb.push_back(e);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " period"},    32'(bus.PERIOD),    32'd0);
    check({tag, " done"},      32'(bus.DONE),      32'd0);
    check({tag, " maximal"},   32'(bus.MAXIMAL),   32'd0);
    check({tag, " zero_lock"}, 32'(bus.ZERO_LOCK), 32'd0);
    check({tag, " timeout"},   32'(bus.TIMEOUT),   32'd0);
    check({tag, " state"},     32'(dut.state),     32'(IDLE));
  endtask

  // Wait (bounded) for a final outcome, then pop and compare the scoreboard entry.
  task automatic check_outcome(input string tag);
    exp_t e;
    int n = 0;
    while (!(bus.DONE || bus.ZERO_LOCK || bus.TIMEOUT) && n < 16) begin
      step(1'b0, 1'b0, 2'b00);
      n++;
    end
    check({tag, " latency"}, 32'(n), 32'd0);
    checks++;
    assert (sb.size() > 0) else begin
      failures++;
      $error("FAIL %s scoreboard observed=empty expected=entry", tag);
    end
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check({tag, " period"},    32'(bus.PERIOD),    32'(e.period));
      check({tag, " done"},      32'(bus.DONE),      32'(e.done));
      check({tag, " maximal"},   32'(bus.MAXIMAL),   32'(e.maximal));
      check({tag, " zero_lock"}, 32'(bus.ZERO_LOCK), 32'(e.zero_lock));
      check({tag, " timeout"},   32'(bus.TIMEOUT),   32'(e.timeout));
    end
  endtask

  initial begin
    RESET     = 1'b1;
    bus.START = 1'b0;
    bus.VALID = 1'b0;
    bus.I     = 2'b00;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RESET = 1'b0;
    #1;
    check_all_zero("reset");
    check("reset ref", 32'(dut.ref_state), 32'd0);

    // Idle with VALID toggling: no measurement without START.
    for (int k = 0; k < 5; k++) begin
      step(1'b0, k[0], 2'($urandom_range(1, 3)));
      check_all_zero("idle");
    end

    // Maximal period: 01,11,10,01.
    step(1'b1, 1'b0, 2'b00);
    push_exp(3'd3, 1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 2'b01);
    step(1'b0, 1'b1, 2'b11);
    step(1'b0, 1'b0, 2'b00);   // gap does not count
    step(1'b0, 1'b1, 2'b10);
    check("max pre done", 32'(bus.DONE), 32'd0);
    step(1'b0, 1'b1, 2'b01);
    check_outcome("max");

    // Zero lock: 01,11,00, then hold.
    step(1'b1, 1'b0, 2'b00);
    check("restart clears done", 32'(bus.DONE), 32'd0);
    push_exp(3'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 2'b01);
    step(1'b0, 1'b1, 2'b11);
    step(1'b0, 1'b1, 2'b00);
    check_outcome("zlock");
    for (int k = 0; k < 3; k++) step(1'b0, 1'b1, 2'b01);
    check("zlock hold", 32'(bus.ZERO_LOCK), 32'd1);
    check("zlock hold done", 32'(bus.DONE), 32'd0);

    // Timeout: 01,11,10,11,10 never returns to 01.
    step(1'b1, 1'b0, 2'b00);
    check("restart clears zlock", 32'(bus.ZERO_LOCK), 32'd0);
    push_exp(3'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 2'b01);
    step(1'b0, 1'b1, 2'b11);
    step(1'b0, 1'b1, 2'b10);
    step(1'b0, 1'b1, 2'b11);
    check("timeout early", 32'(bus.TIMEOUT), 32'd0);
    step(1'b0, 1'b1, 2'b10);
    check_outcome("timeout");

    // Restart mid-measurement; sample alongside START is ignored.
    step(1'b1, 1'b0, 2'b00);
    step(1'b0, 1'b1, 2'b01);
    step(1'b0, 1'b1, 2'b11);
    step(1'b1, 1'b1, 2'b10);
    push_exp(3'd3, 1'b1, 1'b1, 1'b0, 1'b0);
    check("restart state", 32'(dut.state), 32'(CAPTURE));
    check("restart timeout clr", 32'(bus.TIMEOUT), 32'd0);
    step(1'b0, 1'b1, 2'b10);
    check("restart ref", 32'(dut.ref_state), 32'h2);
    step(1'b0, 1'b1, 2'b01);
    step(1'b0, 1'b1, 2'b11);
    step(1'b0, 1'b1, 2'b10);
    check_outcome("restart");

    // Async reset from PASS clears outputs without a clock edge.
    #2;
    RESET = 1'b1;
    #1;
    check_all_zero("async reset pass");
    @(negedge CLK);
    RESET = 1'b0;

    // Async reset during COUNT.
    step(1'b1, 1'b0, 2'b00);
    step(1'b0, 1'b1, 2'b01);
    step(1'b0, 1'b1, 2'b11);
    check("count state", 32'(dut.state), 32'(COUNT));
    #2;
    RESET = 1'b1;
    #1;
    check_all_zero("async reset count");
    @(negedge CLK);
    RESET = 1'b0;
    step(1'b0, 1'b1, 2'b10);
    step(1'b0, 1'b1, 2'b01);
    step(1'b0, 1'b1, 2'b11);
    step(1'b0, 1'b1, 2'b01);
    check_all_zero("post reset no start");

    check("scoreboard drained", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
